// File: rtl/ds3_frame_sync_ctrl.sv
// DS3 frame alignment controller: HUNT -> PRESYNC -> SYNC search on a serial bit stream.
// Define DS3_FSC_ERRCNT_EN to enable the saturating errored-FAW counter on faw_err_cnt.
module ds3_frame_sync_ctrl #(
  parameter int unsigned FRAME_LEN = 25,
  parameter logic [7:0]  FAW       = 8'b10011001,
  parameter int unsigned CONFIRM_N = 3,
  parameter int unsigned LOSS_N    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in,
  input  logic       bit_en,
  output logic [1:0] state,
  output logic       in_sync,
  output logic       frame_pulse,
  output logic [4:0] bit_pos,
  output logic [7:0] faw_err_cnt
);

  typedef enum logic [1:0] {
    HUNT    = 2'b00,
    PRESYNC = 2'b01,
    SYNC    = 2'b10
  } state_t;

  localparam logic [4:0] LAST_POS    = 5'(FRAME_LEN - 1);
  localparam logic [2:0] CONFIRM_CNT = 3'(CONFIRM_N);
  localparam logic [2:0] LOSS_CNT    = 3'(LOSS_N);

  state_t     r_state, w_state_next;
  logic [7:0] r_sr, w_sr_next;
  logic [4:0] r_bit_pos, w_bit_pos_next;
  logic [2:0] r_match_cnt, w_match_cnt_next;
  logic [2:0] r_miss_cnt, w_miss_cnt_next;
  logic       r_in_sync, r_frame_pulse, w_frame_pulse_next;
  logic       w_faw_hit, w_check;

  assign w_sr_next = {r_sr[6:0], in};
  assign w_faw_hit = (w_sr_next == FAW);
  assign w_check   = (r_bit_pos == LAST_POS);

  always_comb begin
    w_state_next       = r_state;
    w_bit_pos_next     = r_bit_pos;
    w_match_cnt_next   = r_match_cnt;
    w_miss_cnt_next    = r_miss_cnt;
    w_frame_pulse_next = 1'b0;
    if (bit_en) begin
      w_bit_pos_next = w_check ? 5'd0 : r_bit_pos + 5'd1;
      unique case (r_state)
        HUNT: begin
          w_bit_pos_next = 5'd0;
          if (w_faw_hit) begin
            w_state_next     = PRESYNC;
            w_match_cnt_next = 3'd1;
          end
        end
        PRESYNC: begin
          if (w_check) begin
            if (w_faw_hit) begin
              w_match_cnt_next = r_match_cnt + 3'd1;
              if (r_match_cnt + 3'd1 >= CONFIRM_CNT) begin
                w_state_next     = SYNC;
                w_match_cnt_next = CONFIRM_CNT;
                w_miss_cnt_next  = 3'd0;
              end
            end else begin
              w_state_next     = HUNT;
              w_match_cnt_next = 3'd0;
            end
          end
        end
        SYNC: begin
          if (w_check) begin
            w_frame_pulse_next = 1'b1;
            if (w_faw_hit) begin
              w_miss_cnt_next = 3'd0;
            end else if (r_miss_cnt + 3'd1 >= LOSS_CNT) begin
              // Loss of alignment drops all history so HUNT starts clean
              w_state_next     = HUNT;
              w_miss_cnt_next  = 3'd0;
              w_match_cnt_next = 3'd0;
            end else begin
              w_miss_cnt_next = r_miss_cnt + 3'd1;
            end
          end
        end
        default: begin
          w_state_next     = HUNT;
          w_bit_pos_next   = 5'd0;
          w_match_cnt_next = 3'd0;
          w_miss_cnt_next  = 3'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= HUNT;
      r_sr          <= 8'd0;
      r_bit_pos     <= 5'd0;
      r_match_cnt   <= 3'd0;
      r_miss_cnt    <= 3'd0;
      r_in_sync     <= 1'b0;
      r_frame_pulse <= 1'b0;
    end else begin
      r_frame_pulse <= w_frame_pulse_next;
      if (bit_en) begin
        r_state     <= w_state_next;
        r_sr        <= w_sr_next;
        r_bit_pos   <= w_bit_pos_next;
        r_match_cnt <= w_match_cnt_next;
        r_miss_cnt  <= w_miss_cnt_next;
        r_in_sync   <= (w_state_next == SYNC);
      end
    end
  end

`ifdef DS3_FSC_ERRCNT_EN
  logic [7:0] r_faw_err_cnt;
  logic       w_sync_miss;

  assign w_sync_miss = bit_en && (r_state == SYNC) && w_check && !w_faw_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_faw_err_cnt <= 8'd0;
    end else if (w_sync_miss && (r_faw_err_cnt != 8'hFF)) begin
      r_faw_err_cnt <= r_faw_err_cnt + 8'd1;
    end
  end

  assign faw_err_cnt = r_faw_err_cnt;
`else
  assign faw_err_cnt = 8'd0;
`endif

  assign state       = r_state;
  assign in_sync     = r_in_sync;
  assign frame_pulse = r_frame_pulse;
  assign bit_pos     = r_bit_pos;

endmodule

// File: tb/tb_ds3_frame_sync_ctrl.sv
// Scoreboard bench for ds3_frame_sync_ctrl: the driver queues expected state/pulse events,
// a negedge monitor pops one whenever the DUT pulses frame_pulse or changes state.
module tb_ds3_frame_sync_ctrl;

  localparam logic [7:0]  FAW_W   = 8'b10011001;
  localparam logic [7:0]  BAD_W   = 8'b10011000;
  localparam logic [24:0] GOOD_F  = {17'd0, FAW_W};
  localparam logic [24:0] BAD_F   = {17'd0, BAD_W};
  localparam logic [24:0] EMBED_F = {5'd0, FAW_W, 4'd0, FAW_W};
`ifdef DS3_FSC_ERRCNT_EN
  localparam bit ERRCNT = 1'b1;
`else
  localparam bit ERRCNT = 1'b0;
`endif

  typedef struct packed {
    logic [1:0]  st;
    logic        sy;
    logic        pl;
    logic [4:0]  bp;
    logic [7:0]  err;
    logic [31:0] bitIdx;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset, dataIn, bitEn;
  logic [1:0] state;
  logic       inSync, framePulse;
  logic [4:0] bitPos;
  logic [7:0] fawErrCnt;

  exp_t expQ[$];
  exp_t expItem, actItem;
  int   assertCount = 0;
  int   failCount   = 0;
  int   bitCount    = 0;
  int   errModel    = 0;
  bit   monEnable   = 1'b0;
  logic [1:0] prevState;

  ds3_frame_sync_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .in         (dataIn),
    .bit_en     (bitEn),
    .state      (state),
    .in_sync    (inSync),
    .frame_pulse(framePulse),
    .bit_pos    (bitPos),
    .faw_err_cnt(fawErrCnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    assertCount++;
    if (actual != expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic expectEvent(input logic [1:0] st, input logic sy, input logic pl, input int offset);
    exp_t e;
    e.st     = st;
    e.sy     = sy;
    e.pl     = pl;
    e.bp     = 5'd0;
    e.err    = ERRCNT ? 8'(errModel) : 8'd0;
    e.bitIdx = 32'(bitCount + offset);
    expQ.push_back(e);
  endtask

  task automatic sendBit(input logic b, input int gap);
    repeat (gap) @(posedge clk);
    if (gap > 0) #1;
    dataIn = b;
    bitEn  = 1'b1;
    @(posedge clk);
    #1;
    bitEn = 1'b0;
    bitCount++;
  endtask

  task automatic applyStimulus(input logic [24:0] frameBits, input int gap);
    for (int i = 24; i >= 0; i--) sendBit(frameBits[i], gap);
  endtask

  task automatic doReset();
    reset  = 1'b1;
    bitEn  = 1'b1;
    dataIn = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    bitEn = 1'b0;
  endtask

  task automatic sendBad();
    if (errModel < 255) errModel++;
    expectEvent(2'b10, 1'b1, 1'b1, 25);
    applyStimulus(BAD_F, 0);
  endtask

  // Five clean frames: PRESYNC at the first FAW, SYNC two frames later, then pulses
  task automatic runAcquire(input int gap);
    for (int f = 1; f <= 5; f++) begin
      if (f == 1) expectEvent(2'b01, 1'b0, 1'b0, 25);
      else if (f == 3) expectEvent(2'b10, 1'b1, 1'b0, 25);
      else if (f >= 4) expectEvent(2'b10, 1'b1, 1'b1, 25);
      applyStimulus(GOOD_F, gap);
    end
  endtask

  always @(negedge clk) begin
    if (monEnable) begin
      if (framePulse || (state != prevState)) begin
        actItem = {state, inSync, framePulse, bitPos, fawErrCnt, 32'(bitCount)};
        assertCount++;
        if (expQ.size() == 0) begin
          failCount++;
          $display("[TB] FAIL unexpectedEvent: got st=%0d sy=%0d pl=%0d bp=%0d err=%0d bit=%0d, expected none",
                   state, inSync, framePulse, bitPos, fawErrCnt, bitCount);
        end else begin
          expItem = expQ.pop_front();
          if (actItem !== expItem) begin
            failCount++;
            $display("[TB] FAIL event: got st=%0d sy=%0d pl=%0d bp=%0d err=%0d bit=%0d, expected st=%0d sy=%0d pl=%0d bp=%0d err=%0d bit=%0d",
                     actItem.st, actItem.sy, actItem.pl, actItem.bp, actItem.err, actItem.bitIdx,
                     expItem.st, expItem.sy, expItem.pl, expItem.bp, expItem.err, expItem.bitIdx);
          end
        end
      end
      prevState = state;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset  = 1'b1;
    bitEn  = 1'b0;
    dataIn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("resetState", state, 0);
    checkOutput("resetInSync", inSync, 0);
    checkOutput("resetPulse", framePulse, 0);
    checkOutput("resetBitPos", bitPos, 0);
    checkOutput("resetErrCnt", fawErrCnt, 0);
    prevState = state;
    monEnable = 1'b1;

    runAcquire(0);

    // Three misses then recovery, including a stray FAW inside the frame
    for (int k = 0; k < 3; k++) sendBad();
    expectEvent(2'b10, 1'b1, 1'b1, 25);
    applyStimulus(EMBED_F, 0);
    expectEvent(2'b10, 1'b1, 1'b1, 25);
    applyStimulus(GOOD_F, 0);

    // Four consecutive misses lose alignment on the fourth check
    for (int k = 0; k < 3; k++) sendBad();
    if (errModel < 255) errModel++;
    expectEvent(2'b00, 1'b0, 1'b1, 25);
    applyStimulus(BAD_F, 0);

    // PRESYNC broken by a bad second FAW, then full re-acquisition
    expectEvent(2'b01, 1'b0, 1'b0, 25);
    applyStimulus(GOOD_F, 0);
    expectEvent(2'b00, 1'b0, 1'b0, 25);
    applyStimulus(BAD_F, 0);
    expectEvent(2'b01, 1'b0, 1'b0, 25);
    applyStimulus(GOOD_F, 0);
    applyStimulus(GOOD_F, 0);
    expectEvent(2'b10, 1'b1, 1'b0, 25);
    applyStimulus(GOOD_F, 0);
    expectEvent(2'b10, 1'b1, 1'b1, 25);
    applyStimulus(GOOD_F, 0);

    // Reset mid-frame while in SYNC
    for (int k = 0; k < 10; k++) sendBit(1'b0, 0);
    checkOutput("midFrameBitPos", bitPos, 10);
    checkOutput("midFrameInSync", inSync, 1);
    errModel = 0;
    expectEvent(2'b00, 1'b0, 1'b0, 0);
    doReset();
    checkOutput("postResetState", state, 0);
    checkOutput("postResetInSync", inSync, 0);
    checkOutput("postResetBitPos", bitPos, 0);
    checkOutput("postResetErrCnt", fawErrCnt, 0);
    runAcquire(0);

    // Sparse bit_en: same bit-level behaviour, pulse still one clock wide
    expectEvent(2'b00, 1'b0, 1'b0, 0);
    doReset();
    runAcquire(2);

    repeat (5) @(posedge clk);
    #1;
    checkOutput("queueEmpty", expQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/ds3_frame_sync_ctrl.md
DS3_FRAME_SYNC_CTRL -- requirements
Module: ds3_frame_sync_ctrl

Interface
REQ-001 Parameter FRAME_LEN, default 25: bits per frame, counted on bit_en strobes.
REQ-002 Parameter FAW, default 8'b10011001: frame alignment word, MSB received first.
REQ-003 Parameter CONFIRM_N, default 3: consecutive correct FAWs needed to declare sync, including the FAW found in HUNT.
REQ-004 Parameter LOSS_N, default 4: consecutive errored FAWs in SYNC that declare loss of alignment.
REQ-005 Port: clk  input  1  system clock; all logic on rising edge.
REQ-006 Port: reset  input  1  synchronous, active-high reset.
REQ-007 Port: in  input  1  serial DS3 data bit, valid when bit_en=1.
REQ-008 Port: bit_en  input  1  one-clk strobe per received bit.
REQ-009 Port: state  output  2  HUNT=00, PRESYNC=01, SYNC=10; 11 is never produced.
REQ-010 Port: in_sync  output  1  high while state=SYNC.
REQ-011 Port: frame_pulse  output  1  one-clk pulse at each FAW check point that occurs in SYNC.
REQ-012 Port: bit_pos  output  5  bit counter within frame, 0..FRAME_LEN-1.
REQ-013 Port: faw_err_cnt  output  8  errored-FAW count (see REQ-029).

Function
REQ-014 All outputs shall be registered; all state holds when bit_en=0.
REQ-015 On each bit_en, an 8-bit shift register sr shall load {sr[6:0], in}; FAW comparisons shall use this new value (sr_next).
REQ-016 HUNT: on bit_en with sr_next==FAW, go to PRESYNC, set bit_pos=0, set match_cnt=1; otherwise stay in HUNT with bit_pos held at 0.
REQ-017 Outside HUNT, bit_pos shall increment on each bit_en and wrap from FRAME_LEN-1 to 0.
REQ-018 The check point is a bit_en with bit_pos==FRAME_LEN-1, i.e. exactly FRAME_LEN bits after the previous FAW end.
REQ-019 PRESYNC, check point, sr_next==FAW: increment match_cnt; on reaching CONFIRM_N, go to SYNC and clear miss_cnt.
REQ-020 PRESYNC, check point, sr_next!=FAW: go to HUNT, clear match_cnt and bit_pos, with no FAW search on that same bit.
REQ-021 SYNC, check point, match: clear miss_cnt and assert frame_pulse in the next cycle.
REQ-022 SYNC, check point, mismatch: increment miss_cnt and assert frame_pulse; on reaching LOSS_N, go to HUNT and clear bit_pos.
REQ-023 No FAW search outside HUNT; a FAW appearing at a non-check position shall be ignored.
REQ-024 Counters: match_cnt and miss_cnt shall be 3 bits and never exceed their thresholds.
REQ-025 in_sync and state shall change on the same edge as the transition.

Reset
REQ-026 When reset=1, the next edge shall force state=HUNT, sr=0, bit_pos=0, match_cnt=0, miss_cnt=0, in_sync=0, frame_pulse=0, faw_err_cnt=0, in any state and regardless of bit_en.
REQ-027 Reset shall take priority over bit_en on the same edge.
REQ-028 A reset asserted mid-frame shall discard all alignment history; the search restarts from HUNT.

Configuration
REQ-029 With macro DS3_FSC_ERRCNT_EN defined, faw_err_cnt shall increment on each SYNC mismatch and saturate at 255.
REQ-030 Without DS3_FSC_ERRCNT_EN, the port shall remain and shall be constant 0, with no counter logic.

Verification
REQ-031 Clean framed stream (FAW every 25 bits, bit_en every clk) -> PRESYNC at the first FAW end; SYNC/in_sync=1 at the 2nd check (50 bits later); frame_pulse every 25 clk.
REQ-032 In SYNC, corrupt 3 consecutive FAWs then send good ones -> stays SYNC; miss_cnt 1,2,3 then 0; faw_err_cnt=3 with the macro, 0 without.
REQ-033 In SYNC, corrupt 4 consecutive FAWs -> HUNT on the 4th check edge; in_sync=0 on that same edge.
REQ-034 PRESYNC with a corrupted 2nd FAW -> HUNT; full re-acquisition needs 3 further good FAWs.
REQ-035 bit_en every 3rd clk -> same bit-level results as REQ-031; frame_pulse still 1 clk wide.
REQ-036 Reset pulsed while in SYNC mid-frame -> all outputs 0 / HUNT on the next edge; re-acquire as in REQ-031.
